// File: rtl/prbs_derandomizer.sv
// -----------------------------------------------------------------------------
// prbs_derandomizer
//
// Receive-side counterpart of the 15-bit PRBS randomizer (1 + x^14 + x^15).
// The LFSR is reloaded with SEED on every frame_start. Each accepted bit is
// XORed with the regenerated PRBS bit to recover the original data. Recovered
// bits are emitted serially and also packed MSB-first into nibbles.
//
// Parameters:
//   SEED        LFSR value loaded at every frame start
//   FRAME_BITS  data bits per frame (multiple of 4, >= 4)
//
// Ports:
//   clk           rising-edge clock
//   reset         asynchronous active-low reset
//   frame_start   one-cycle frame start pulse (IDLE or RUN)
//   in_valid      in_bit is valid this cycle
//   in_bit        randomized serial data
//   out_bit       recovered bit (registered)
//   out_valid     out_bit valid
//   nibble_out    last four recovered bits, first-received bit in [3]
//   nibble_valid  one-cycle pulse when nibble_out updates
//   frame_done    one-cycle pulse with the final bit of a frame
//   resync        one-cycle pulse when frame_start arrives in RUN
//   busy          high while in RUN
// -----------------------------------------------------------------------------
module prbs_derandomizer #(
    parameter logic [14:0] SEED       = 15'b100101010000000,
    parameter int          FRAME_BITS = 32
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       frame_start,
    input  logic       in_valid,
    input  logic       in_bit,
    output logic       out_bit,
    output logic       out_valid,
    output logic [3:0] nibble_out,
    output logic       nibble_valid,
    output logic       frame_done,
    output logic       resync,
    output logic       busy
);

    localparam int CNT_W = (FRAME_BITS > 1) ? $clog2(FRAME_BITS) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME_BITS - 1);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t state, state_next;

    logic [14:0]      lfsr, lfsr_base, lfsr_next;
    logic [CNT_W-1:0] cnt, cnt_base, cnt_next;
    // Only the three earlier bits of a nibble need storing; the fourth is
    // the bit being recovered when the nibble completes.
    logic [2:0]       shreg, shreg_base, shreg_next;
    logic             prbs;
    logic             accept;
    logic             rec_bit;
    logic             last_bit;
    logic             nibble_edge;

    // A frame_start substitutes the restart values for the held state, so a
    // coincident in_valid bit is processed as bit 0 of the new frame.
    always_comb begin
        lfsr_base   = frame_start ? SEED : lfsr;
        cnt_base    = frame_start ? '0 : cnt;
        shreg_base  = frame_start ? '0 : shreg;
        prbs        = lfsr_base[14] ^ lfsr_base[13];
        accept      = in_valid && (frame_start || (state == RUN));
        rec_bit     = in_bit ^ prbs;
        last_bit    = accept && (cnt_base == LAST_CNT);
        nibble_edge = accept && (cnt_base[1:0] == 2'b11);

        lfsr_next  = lfsr_base;
        cnt_next   = cnt_base;
        shreg_next = shreg_base;
        if (accept) begin
            lfsr_next  = {lfsr_base[13:0], prbs};
            cnt_next   = last_bit ? '0 : cnt_base + CNT_W'(1);
            shreg_next = {shreg_base[1:0], rec_bit};
        end
    end

    // FSM: state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // FSM: next-state logic
    always_comb begin
        state_next = state;
        if (frame_start) begin
            state_next = RUN;
        end else if (last_bit) begin
            state_next = IDLE;
        end
    end

    // FSM: outputs
    always_comb begin
        busy = (state == RUN);
    end

    // Datapath and registered outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lfsr         <= SEED;
            cnt          <= '0;
            shreg        <= '0;
            out_bit      <= 1'b0;
            out_valid    <= 1'b0;
            nibble_out   <= 4'h0;
            nibble_valid <= 1'b0;
            frame_done   <= 1'b0;
            resync       <= 1'b0;
        end else begin
            lfsr         <= lfsr_next;
            cnt          <= cnt_next;
            shreg        <= shreg_next;
            out_valid    <= accept;
            nibble_valid <= nibble_edge;
            frame_done   <= last_bit;
            resync       <= frame_start && (state == RUN);
            if (accept) begin
                out_bit <= rec_bit;
            end
            if (nibble_edge) begin
                nibble_out <= {shreg_base, rec_bit};
            end
        end
    end

endmodule

// File: tb/tb_prbs_derandomizer.sv
// -----------------------------------------------------------------------------
// tb_prbs_derandomizer
//
// Directed bench for prbs_derandomizer. Inputs change 1 ns after a rising
// edge; outputs are sampled at that same point, reflecting the edge just
// taken. A small randomizer with the same seed produces the loopback frame.
// -----------------------------------------------------------------------------
module tb_prbs_derandomizer;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       frame_start = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_bit = 1'b0;
    logic       out_bit;
    logic       out_valid;
    logic [3:0] nibble_out;
    logic       nibble_valid;
    logic       frame_done;
    logic       resync;
    logic       busy;

    int n_chk  = 0;
    int n_fail = 0;

    localparam logic [14:0] TB_SEED = 15'b100101010000000;
    localparam logic [31:0] FRAME_DATA = 32'hA5C3_19E7;

    logic [3:0] exp_nib [8] = '{4'hA, 4'h5, 4'hC, 4'h3, 4'h1, 4'h9, 4'hE, 4'h7};
    logic [7:0] exp_zero_bits = 8'b1011_1111;

    prbs_derandomizer dut (
        .clk          (clk),
        .reset        (reset),
        .frame_start  (frame_start),
        .in_valid     (in_valid),
        .in_bit       (in_bit),
        .out_bit      (out_bit),
        .out_valid    (out_valid),
        .nibble_out   (nibble_out),
        .nibble_valid (nibble_valid),
        .frame_done   (frame_done),
        .resync       (resync),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One clock with the given inputs, then release them.
    task automatic tick(input logic fs, input logic v, input logic b);
        frame_start = fs;
        in_valid    = v;
        in_bit      = b;
        @(posedge clk);
        #1;
        frame_start = 1'b0;
        in_valid    = 1'b0;
        in_bit      = 1'b0;
    endtask

    // Full 32-bit loopback frame with 0..max_gap idle cycles between bits.
    task automatic run_frame(input int max_gap, input string name);
        logic [14:0] m;
        logic        d, p;
        int          idx;
        int          gap;
        m   = TB_SEED;
        idx = 0;
        tick(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 32; i++) begin
            d = FRAME_DATA[31 - i];
            p = m[14] ^ m[13];
            m = {m[13:0], p};
            tick(1'b0, 1'b1, d ^ p);
            chk({name, "_out_bit"}, out_bit, d);
            if (nibble_valid) begin
                if (idx < 8) chk({name, "_nibble"}, nibble_out, exp_nib[idx]);
                chk({name, "_frame_done"}, frame_done, (idx == 7));
                idx++;
            end
            gap = (max_gap > 0) ? $urandom_range(0, max_gap) : 0;
            for (int g = 0; g < gap; g++) begin
                tick(1'b0, 1'b0, 1'b0);
                chk({name, "_gap_out_valid"}, out_valid, 1'b0);
            end
        end
        chk({name, "_nibble_count"}, idx, 8);
        chk({name, "_busy_after"}, busy, 1'b0);
        for (int k = 0; k < 3; k++) begin
            tick(1'b0, 1'b1, 1'b1);
            chk({name, "_extra_out_valid"}, out_valid, 1'b0);
        end
    endtask

    initial begin
        // Reset state
        #12;
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_nibble_out", nibble_out, 4'h0);
        @(posedge clk);
        #1;
        reset = 1'b1;

        // in_valid in IDLE without frame_start is ignored
        tick(1'b0, 1'b1, 1'b0);
        chk("idle_out_valid", out_valid, 1'b0);

        // Frame start from IDLE, then 8 zero bits
        tick(1'b1, 1'b0, 1'b0);
        chk("fs_idle_resync", resync, 1'b0);
        chk("fs_idle_busy", busy, 1'b1);
        for (int i = 0; i < 8; i++) begin
            tick(1'b0, 1'b1, 1'b0);
            chk("zero_out_valid", out_valid, 1'b1);
            chk("zero_out_bit", out_bit, exp_zero_bits[7 - i]);
            chk("zero_nibble_valid", nibble_valid, (i == 3 || i == 7));
            if (i == 3) chk("zero_nib0", nibble_out, 4'hB);
            if (i == 7) chk("zero_nib1", nibble_out, 4'hF);
        end

        // Restart in RUN, then 8 one bits
        tick(1'b1, 1'b0, 1'b0);
        chk("fs_run_resync", resync, 1'b1);
        tick(1'b0, 1'b1, 1'b1);
        chk("resync_one_cycle", resync, 1'b0);
        for (int i = 1; i < 8; i++) begin
            tick(1'b0, 1'b1, 1'b1);
            if (i == 3) chk("one_nib0", nibble_out, 4'h4);
            if (i == 7) chk("one_nib1", nibble_out, 4'h0);
        end

        // frame_start with coincident bit: bit 0 uses PRBS from SEED
        tick(1'b1, 1'b1, 1'b0);
        chk("coinc_resync", resync, 1'b1);
        chk("coinc_out_valid", out_valid, 1'b1);
        chk("coinc_out_bit", out_bit, 1'b1);
        tick(1'b0, 1'b1, 1'b0);
        chk("coinc_bit1", out_bit, 1'b0);

        // Restart after 6 bits: pending bits dropped, next 4 zeros give B
        tick(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) tick(1'b0, 1'b1, 1'b1);
        tick(1'b1, 1'b0, 1'b0);
        chk("mid_resync", resync, 1'b1);
        chk("mid_nibble_valid", nibble_valid, 1'b0);
        for (int i = 0; i < 4; i++) begin
            tick(1'b0, 1'b1, 1'b0);
            chk("mid_nibble_valid_pos", nibble_valid, (i == 3));
        end
        chk("mid_nib", nibble_out, 4'hB);

        // Loopback frames, gap-free and with random gaps
        run_frame(0, "lb");
        run_frame(3, "gap");

        // Reset asserted at bit 10
        tick(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) tick(1'b0, 1'b1, 1'b0);
        chk("pre_rst_nib", nibble_out, 4'hF);
        #2;
        reset = 1'b0;
        #1;
        chk("async_out_bit", out_bit, 1'b0);
        chk("async_out_valid", out_valid, 1'b0);
        chk("async_nibble_out", nibble_out, 4'h0);
        chk("async_nibble_valid", nibble_valid, 1'b0);
        chk("async_frame_done", frame_done, 1'b0);
        chk("async_resync", resync, 1'b0);
        chk("async_busy", busy, 1'b0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick(1'b0, 1'b1, 1'b1);
            chk("post_rst_out_valid", out_valid, 1'b0);
            chk("post_rst_busy", busy, 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
